// File: rtl/match_stream_packer.sv
// match_stream_packer: buffers per-frame match records and emits each closed
// frame as a header word followed by its records on a valid/ready stream.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no frame on the output; loads the next descriptor if any
// S_HDR  | header word on m_data, waiting for handshake
// S_BODY | record words from the FIFO, r_rem of them still to send
module match_stream_packer #(
  parameter int DEPTH      = 256,
  parameter int DESC_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        match_valid,
  input  logic [63:0] match_data,
  input  logic        match_done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_last,
  output logic        overflow,
  output logic [15:0] drop_frames
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DAW = $clog2(DESC_DEPTH);
  localparam int DCW = DAW + 1;
  localparam logic [CW-1:0] FIFO_LIM = DEPTH[CW-1:0];
  localparam logic [DCW:0]  DESC_LIM = DESC_DEPTH[DCW:0];

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;

  logic          r_in_valid, r_in_done;
  logic [63:0]   r_in_data;
  logic          r_open, r_admit, r_ovf, r_overflow;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_frame_id, r_drop;

  logic [63:0]   r_fifo [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_fifo_cnt;

  logic [32:0]    r_desc [DESC_DEPTH];
  logic [DAW-1:0] r_dwr_ptr, r_drd_ptr;
  logic [DCW-1:0] r_desc_cnt;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cur_cnt, r_cur_id, r_rem;
  logic        r_cur_ovf;

  logic          w_first, w_resv, w_slot_free, w_adm, w_full;
  logic          w_wr, w_lost, w_push, w_drop, w_ovf_nxt, w_desc_empty;
  logic          w_load, w_rec_pop, w_desc_pop;
  logic [DCW:0]  w_desc_used;
  logic [CW-1:0] w_cnt_nxt;
  logic [32:0]   w_desc_wdata, w_desc_head;

  // The open frame holds one reserved slot until its descriptor is pushed.
  assign w_resv       = r_open & r_admit;
  assign w_desc_used  = {1'b0, r_desc_cnt} + {{DCW{1'b0}}, w_resv};
  assign w_slot_free  = w_desc_used < DESC_LIM;
  assign w_first      = (r_in_valid | r_in_done) & ~r_open;
  assign w_adm        = r_open ? r_admit : w_slot_free;
  assign w_full       = r_fifo_cnt == FIFO_LIM;
  assign w_wr         = r_in_valid & w_adm & ~w_full;
  assign w_lost       = r_in_valid & w_adm & w_full;
  assign w_cnt_nxt    = r_cnt + {{(CW-1){1'b0}}, w_wr};
  assign w_ovf_nxt    = r_ovf | w_lost;
  assign w_push       = r_in_done & w_adm;
  assign w_drop       = r_in_done & ~w_adm;
  assign w_desc_wdata = {{(16-CW){1'b0}}, w_cnt_nxt, w_ovf_nxt, r_frame_id};
  assign w_desc_head  = r_desc[r_drd_ptr];
  assign w_desc_empty = r_desc_cnt == '0;
  assign overflow     = r_overflow;
  assign drop_frames  = r_drop;

  // Register the producer inputs once so admission sees clean, aligned events.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_in_done  <= 1'b0;
      r_in_data  <= '0;
    end else begin
      r_in_valid <= match_valid;
      r_in_done  <= match_done;
      r_in_data  <= match_data;
    end
  end

  // Track the open frame: admission, record count, loss flags and frame id.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_open     <= 1'b0;
      r_admit    <= 1'b0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_frame_id <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_in_done) begin
        r_open     <= 1'b0;
        r_admit    <= 1'b0;
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
        r_frame_id <= r_frame_id + 16'd1;
      end else begin
        if (w_first) begin
          r_open  <= 1'b1;
          r_admit <= w_slot_free;
        end
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (w_drop || w_lost) r_overflow <= 1'b1;
    end
  end

  // Record FIFO storage.
  always_ff @(posedge clk) begin
    if (w_wr) r_fifo[r_wr_ptr] <= r_in_data;
  end

  // Record FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rec_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rec_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Descriptor queue storage.
  always_ff @(posedge clk) begin
    if (w_push) r_desc[r_dwr_ptr] <= w_desc_wdata;
  end

  // Descriptor queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwr_ptr  <= '0;
      r_drd_ptr  <= '0;
      r_desc_cnt <= '0;
    end else begin
      if (w_push) r_dwr_ptr <= r_dwr_ptr + DAW'(1);
      if (w_desc_pop) r_drd_ptr <= r_drd_ptr + DAW'(1);
      case ({w_push, w_desc_pop})
        2'b10:   r_desc_cnt <= r_desc_cnt + DCW'(1);
        2'b01:   r_desc_cnt <= r_desc_cnt - DCW'(1);
        default: r_desc_cnt <= r_desc_cnt;
      endcase
    end
  end

  // Output FSM state, current descriptor and remaining body words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cur_cnt <= '0;
      r_cur_ovf <= 1'b0;
      r_cur_id  <= '0;
      r_rem     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cur_cnt <= w_desc_head[32:17];
        r_cur_ovf <= w_desc_head[16];
        r_cur_id  <= w_desc_head[15:0];
        r_rem     <= w_desc_head[32:17];
      end else if (w_rec_pop) begin
        r_rem <= r_rem - 16'd1;
      end
    end
  end

  // Output FSM next state and stream outputs; descriptor pops on the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rec_pop   = 1'b0;
    w_desc_pop  = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_desc_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        m_valid = 1'b1;
        m_data  = {8'hA5, 8'h00, r_cur_id, 15'h0, r_cur_ovf, r_cur_cnt};
        m_last  = r_cur_cnt == 16'd0;
        if (m_ready) begin
          if (r_cur_cnt == 16'd0) begin
            w_desc_pop  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BODY;
          end
        end
      end
      S_BODY: begin
        m_valid = 1'b1;
        m_data  = r_fifo[r_rd_ptr];
        m_last  = r_rem == 16'd1;
        if (m_ready) begin
          w_rec_pop = 1'b1;
          if (r_rem == 16'd1) begin
            w_desc_pop  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_match_stream_packer.sv
// Bench for match_stream_packer with a small record FIFO (16) and 4 descriptor slots.
module tb_match_stream_packer;
  localparam int DEPTH      = 16;
  localparam int DESC_DEPTH = 4;
  localparam int NF         = 12;

  logic        clk = 1'b0;
  logic        rst, match_valid, match_done, m_ready;
  logic [63:0] match_data;
  logic        m_valid, m_last, overflow;
  logic [63:0] m_data;
  logic [15:0] drop_frames;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [15:0] exp_id = 16'd0;
  logic [15:0] exp_drops = 16'd0;
  logic [63:0] got_d[$];
  logic        got_l[$];
  logic [63:0] exp_d[$];
  logic        exp_l[$];
  int          frames_fin = 0;
  int          frames_sent = 0;

  match_stream_packer #(.DEPTH(DEPTH), .DESC_DEPTH(DESC_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .match_valid(match_valid), .match_data(match_data), .match_done(match_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .overflow(overflow), .drop_frames(drop_frames)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] hdr(input logic [15:0] id, input logic ovf, input logic [15:0] cnt);
    hdr = {8'hA5, 8'h00, id, 15'h0, ovf, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rec(input logic [63:0] d);
    match_valid = 1'b1;
    match_data  = d;
    tick();
    match_valid = 1'b0;
  endtask

  task automatic send_done();
    match_done = 1'b1;
    tick();
    match_done = 1'b0;
  endtask

  // Gathers up to n handshaked words within budget cycles; no checking here.
  task automatic collect(input int n, input int budget);
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < budget && got_d.size() < n; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_chk++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", m_last); end
    n_chk++; if (m_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", m_data); end
    n_chk++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_chk++; if (drop_frames !== 16'h0) begin n_bad++; $display("FAIL reset_drops: got %0d want 0", drop_frames); end
    rst = 1'b0;
    exp_id = 16'd0;
    exp_drops = 16'd0;
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] w[4];
    w[0] = 64'hA500_0000_0000_0003; w[1] = 64'h1; w[2] = 64'h2; w[3] = 64'h3;
    m_ready = 1'b1;
    send_rec(64'h1);
    send_rec(64'h2);
    send_rec(64'h3);
    send_done();
    tick();
    n_chk++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", m_valid); end
    tick();
    n_chk++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL basic_hdr_latency: got %b want 1", m_valid); end
    collect(4, 20);
    n_chk++;
    if (got_d.size() != 4) begin
      n_bad++; $display("FAIL basic_words: got %0d words want 4", got_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (got_d[k] !== w[k] || got_l[k] !== (k == 3)) begin
          n_bad++; $display("FAIL basic_word%0d: got %h last %b want %h last %b", k, got_d[k], got_l[k], w[k], k == 3);
        end
      end
    end
    exp_id = exp_id + 16'd1;
  endtask

  task automatic test_empty();
    m_ready = 1'b1;
    send_done();
    collect(1, 10);
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== hdr(exp_id, 1'b0, 16'd0) || got_l[0] !== 1'b1) begin
      n_bad++; $display("FAIL empty_hdr: got %0d words first %h want %h last 1", got_d.size(), got_d.size() > 0 ? got_d[0] : 64'h0, hdr(exp_id, 1'b0, 16'd0));
    end
    exp_id = exp_id + 16'd1;
    send_rec(64'hCAFE);
    send_done();
    collect(2, 12);
    n_chk++;
    if (got_d.size() != 2 || got_d[0] !== hdr(exp_id, 1'b0, 16'd1) || got_d[1] !== 64'hCAFE || got_l[1] !== 1'b1) begin
      n_bad++; $display("FAIL empty_next_id: got %0d words hdr %h want %h", got_d.size(), got_d.size() > 0 ? got_d[0] : 64'h0, hdr(exp_id, 1'b0, 16'd1));
    end
    exp_id = exp_id + 16'd1;
  endtask

  task automatic test_rec_overflow();
    logic [63:0] recs[20];
    m_ready = 1'b0;
    n_chk++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL recovf_pre: overflow got %b want 0", overflow); end
    for (int k = 0; k < 20; k++) begin
      recs[k] = {$urandom, $urandom};
      send_rec(recs[k]);
    end
    send_done();
    repeat (3) tick();
    n_chk++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL recovf_flag: got %b want 1", overflow); end
    m_ready = 1'b1;
    collect(17, 60);
    n_chk++;
    if (got_d.size() != 17) begin
      n_bad++; $display("FAIL recovf_words: got %0d want 17", got_d.size());
    end else begin
      n_chk++;
      if (got_d[0] !== hdr(exp_id, 1'b1, 16'd16) || got_l[0] !== 1'b0) begin
        n_bad++; $display("FAIL recovf_hdr: got %h want %h", got_d[0], hdr(exp_id, 1'b1, 16'd16));
      end
      for (int k = 0; k < 16; k++) begin
        n_chk++;
        if (got_d[k+1] !== recs[k] || got_l[k+1] !== (k == 15)) begin
          n_bad++; $display("FAIL recovf_rec%0d: got %h last %b want %h last %b", k, got_d[k+1], got_l[k+1], recs[k], k == 15);
        end
      end
    end
    n_chk++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL recovf_extra: m_valid got %b want 0", m_valid); end
    exp_id = exp_id + 16'd1;
  endtask

  task automatic test_desc_overflow();
    logic [63:0] recs[6];
    m_ready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      recs[f] = {$urandom, $urandom};
      send_rec(recs[f]);
      send_done();
    end
    exp_drops = exp_drops + 16'd2;
    repeat (3) tick();
    n_chk++; if (drop_frames !== exp_drops) begin n_bad++; $display("FAIL descovf_drops: got %0d want %0d", drop_frames, exp_drops); end
    n_chk++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL descovf_flag: got %b want 1", overflow); end
    m_ready = 1'b1;
    collect(8, 60);
    n_chk++;
    if (got_d.size() != 8) begin
      n_bad++; $display("FAIL descovf_words: got %0d want 8", got_d.size());
    end else begin
      for (int f = 0; f < 4; f++) begin
        n_chk++;
        if (got_d[2*f] !== hdr(exp_id + 16'(f), 1'b0, 16'd1) || got_d[2*f+1] !== recs[f] || got_l[2*f] !== 1'b0 || got_l[2*f+1] !== 1'b1) begin
          n_bad++; $display("FAIL descovf_frame%0d: got %h/%h want %h/%h", f, got_d[2*f], got_d[2*f+1], hdr(exp_id + 16'(f), 1'b0, 16'd1), recs[f]);
        end
      end
    end
    repeat (3) tick();
    n_chk++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL descovf_extra: m_valid got %b want 0", m_valid); end
    exp_id = exp_id + 16'd6;
  endtask

  task automatic test_back_to_back();
    int          f_n[NF];
    logic        f_same[NF];
    int          f_gap[NF];
    logic [63:0] rec_q[$];
    exp_d.delete(); exp_l.delete(); rec_q.delete();
    frames_fin = 0;
    frames_sent = 0;
    for (int f = 0; f < NF; f++) begin
      f_n[f]    = (f == 0) ? 1 : int'($urandom_range(0, 4));
      f_same[f] = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      f_gap[f]  = int'($urandom_range(0, 2));
      exp_d.push_back(hdr(exp_id + 16'(f), 1'b0, 16'(f_n[f])));
      exp_l.push_back(f_n[f] == 0);
      for (int r = 0; r < f_n[f]; r++) begin
        logic [63:0] d;
        d = {$urandom, $urandom};
        rec_q.push_back(d);
        exp_d.push_back(d);
        exp_l.push_back(r == f_n[f] - 1);
      end
    end
    m_ready = 1'b0;
    fork
      begin : drv
        int ri;
        ri = 0;
        for (int f = 0; f < NF; f++) begin
          int g;
          g = 0;
          while ((frames_sent - frames_fin) >= 2 && g < 400) begin tick(); g++; end
          for (int r = 0; r < f_n[f]; r++) begin
            match_valid = 1'b1;
            match_data  = rec_q[ri];
            ri++;
            if (r == f_n[f] - 1 && f_same[f]) match_done = 1'b1;
            tick();
            match_valid = 1'b0;
            match_done  = 1'b0;
          end
          if (!(f_n[f] > 0 && f_same[f])) send_done();
          frames_sent++;
          repeat (f_gap[f]) tick();
        end
      end
      begin : mon
        logic        prev_stall;
        logic [63:0] prev_d;
        logic        prev_l;
        int          cyc;
        prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0; cyc = 0;
        while (exp_d.size() > 0 && cyc < 4000) begin
          @(negedge clk);
          if (prev_stall) begin
            n_chk++;
            if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
              n_bad++; $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", m_valid, m_data, m_last, prev_d, prev_l);
            end
          end
          if (m_valid && m_ready) begin
            n_chk++;
            if (m_data !== exp_d[0] || m_last !== exp_l[0]) begin
              n_bad++; $display("FAIL stream_word: got %h last %b want %h last %b", m_data, m_last, exp_d[0], exp_l[0]);
            end
            if (exp_l[0]) frames_fin++;
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
          end
          prev_stall = m_valid && !m_ready;
          prev_d = m_data;
          prev_l = m_last;
          tick();
          m_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
      end
    join
    n_chk++; if (exp_d.size() != 0) begin n_bad++; $display("FAIL stream_timeout: %0d words missing want 0", exp_d.size()); end
    m_ready = 1'b1;
    repeat (3) tick();
    n_chk++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL stream_extra: m_valid got %b want 0", m_valid); end
    n_chk++; if (drop_frames !== exp_drops) begin n_bad++; $display("FAIL stream_drops: got %0d want %0d", drop_frames, exp_drops); end
    exp_id = exp_id + 16'(NF);
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    m_ready = 1'b0;
    send_rec(64'h11);
    send_rec(64'h22);
    send_rec(64'h33);
    send_done();
    repeat (3) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 64'h11 || m_last !== 1'b0) begin
      n_bad++; $display("FAIL midrst_body: got v=%b d=%h l=%b want v=1 d=11 l=0", m_valid, m_data, m_last);
    end
    rst = 1'b1;
    tick();
    n_chk++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", m_valid); end
    n_chk++; if (m_data !== 64'h0 || m_last !== 1'b0) begin n_bad++; $display("FAIL midrst_data: got %h/%b want 0/0", m_data, m_last); end
    n_chk++; if (overflow !== 1'b0 || drop_frames !== 16'h0) begin n_bad++; $display("FAIL midrst_counters: got %b/%0d want 0/0", overflow, drop_frames); end
    rst = 1'b0;
    exp_id = 16'd0;
    exp_drops = 16'd0;
    tick();
    m_ready = 1'b1;
    d = {$urandom, $urandom};
    send_rec(d);
    send_done();
    collect(2, 12);
    n_chk++;
    if (got_d.size() != 2 || got_d[0] !== hdr(16'd0, 1'b0, 16'd1) || got_d[1] !== d || got_l[1] !== 1'b1) begin
      n_bad++; $display("FAIL midrst_frame: got %0d words hdr %h want %h", got_d.size(), got_d.size() > 0 ? got_d[0] : 64'h0, hdr(16'd0, 1'b0, 16'd1));
    end
    repeat (2) tick();
    n_chk++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_extra: m_valid got %b want 0", m_valid); end
  endtask

  initial begin
    rst = 1'b1;
    match_valid = 1'b0;
    match_done = 1'b0;
    match_data = '0;
    m_ready = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_rec_overflow();
    test_desc_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
